// File: rtl/cic_interp.sv
// cic_interp: five-stage CIC interpolator (M = 1).
// Low-rate samples are taken over a request/tick handshake, pushed through a
// comb pipeline (one stage per clock), zero-stuffed by INTERP, integrated at the
// clock rate, then gain-shifted and saturated into one output sample per clock.
module cic_interp #(
    parameter int unsigned WIDTH      = 74,
    parameter int unsigned INTERP     = 5000,
    parameter int unsigned BITS       = 16,
    parameter int unsigned GAIN_BITS  = 6,
    parameter int unsigned SHIFT_BASE = 52
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic signed [BITS-1:0] x_in,
    input  logic                  in_tick,
    input  logic [GAIN_BITS-1:0]  gain,
    input  logic                  clr_status,
    output logic                  in_req,
    output logic signed [BITS-1:0] x_out,
    output logic                  underrun,
    output logic                  overrun
);

    localparam int NStages = 5;
    localparam logic [15:0] PhaseLast = 16'(INTERP - 1);

    // Output clamp limits, sign-extended to the accumulator width.
    localparam logic signed [WIDTH-1:0] SatMax =
        {{(WIDTH - BITS + 1){1'b0}}, {(BITS - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SatMin =
        {{(WIDTH - BITS + 1){1'b1}}, {(BITS - 1){1'b0}}};

    // Low-rate timing
    logic [15:0]            r_phase;
    logic                   w_consume;

    // Input holding stage
    logic signed [BITS-1:0] r_hold;
    logic                   r_pending;
    logic signed [WIDTH-1:0] w_hold_ext;
    logic                   r_in_req;
    logic                   r_underrun;
    logic                   r_overrun;
    logic                   w_under_set;
    logic                   w_over_set;

    // Comb pipeline; r_stage_vld[k] marks that stage k's input is fresh this cycle,
    // and r_stage_vld[NStages] marks the single edge on which comb5 feeds integ1.
    logic signed [WIDTH-1:0] r_comb_in;
    logic [NStages:0]        r_stage_vld;
    logic signed [WIDTH-1:0] w_comb_src [NStages];
    logic signed [WIDTH-1:0] r_comb_out [NStages];
    logic signed [WIDTH-1:0] r_comb_dly [NStages];

    // Integrators and output stage
    logic signed [WIDTH-1:0] w_integ_in;
    logic signed [WIDTH-1:0] r_integ [NStages];
    int unsigned             w_shift;
    logic signed [WIDTH-1:0] w_shifted;
    logic signed [WIDTH-1:0] w_sat;
    logic signed [BITS-1:0]  r_x_out;

    assign w_consume   = (r_phase == PhaseLast);
    assign w_hold_ext  = {{(WIDTH - BITS){r_hold[BITS-1]}}, r_hold};
    assign w_under_set = w_consume & ~r_pending;
    // A tick landing on the consume edge replaces a value that is being consumed.
    assign w_over_set  = in_tick & r_pending & ~w_consume;

    assign in_req   = r_in_req;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;
    assign x_out    = r_x_out;

    // Phase counter: 0..INTERP-1, consume happens on the wrap edge.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_phase <= '0;
        end else if (w_consume) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 16'd1;
        end
    end

    // Holding register, pending flag, comb input capture and request pulse.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_comb_in <= '0;
            r_in_req  <= 1'b0;
        end else begin
            r_in_req <= w_consume;
            if (w_consume) begin
                r_comb_in <= r_pending ? w_hold_ext : '0;
            end
            if (in_tick) begin
                r_hold    <= x_in;
                r_pending <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Sticky status flags; a set on the same edge beats a clear.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_under_set | (r_underrun & ~clr_status);
            r_overrun  <= w_over_set | (r_overrun & ~clr_status);
        end
    end

    // Stage-valid shift register: stage k fires at consume edge + k + 1.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_stage_vld <= '0;
        end else begin
            r_stage_vld <= {r_stage_vld[NStages-1:0], w_consume};
        end
    end

    // Route each comb stage's input: the captured sample, then the previous stage.
    always_comb begin
        w_comb_src[0] = r_comb_in;
        for (int k = 1; k < NStages; k++) begin
            w_comb_src[k] = r_comb_out[k-1];
        end
    end

    // Comb stages: difference against the previous low-rate value, once per sample.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            for (int k = 0; k < NStages; k++) begin
                r_comb_out[k] <= '0;
                r_comb_dly[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NStages; k++) begin
                if (r_stage_vld[k]) begin
                    r_comb_out[k] <= w_comb_src[k] - r_comb_dly[k];
                    r_comb_dly[k] <= w_comb_src[k];
                end
            end
        end
    end

    // Zero-stuffing: comb5 reaches the integrators on one edge per low-rate period.
    always_comb begin
        w_integ_in = '0;
        if (r_stage_vld[NStages]) begin
            w_integ_in = r_comb_out[NStages-1];
        end
    end

    // Integrator chain at clock rate; two's-complement wrap is relied upon.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            for (int k = 0; k < NStages; k++) begin
                r_integ[k] <= '0;
            end
        end else begin
            r_integ[0] <= r_integ[0] + w_integ_in;
            for (int k = 1; k < NStages; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Gain to shift, arithmetic scale and clamp of the last integrator.
    always_comb begin
        w_shift = 0;
        if (32'(gain) < SHIFT_BASE) begin
            w_shift = SHIFT_BASE - 32'(gain);
        end
        w_shifted = r_integ[NStages-1] >>> w_shift;
        w_sat     = w_shifted;
        if (w_shifted > SatMax) begin
            w_sat = SatMax;
        end else if (w_shifted < SatMin) begin
            w_sat = SatMin;
        end
    end

    // Registered output sample.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_x_out <= '0;
        end else begin
            r_x_out <= w_sat[BITS-1:0];
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp with INTERP = 8, SHIFT_BASE = 12 (gain 0 is unity).
// The reference model treats the filter as its impulse response
// (1 + z^-1 + ... + z^-(R-1))^5 applied to the consumed low-rate samples,
// delayed 11 clocks from the consume edge, then shifted and clamped.
module tb_cic_interp;

    localparam int R    = 8;
    localparam int SB   = 12;
    localparam int W    = 40;
    localparam int Taps = 5 * (R - 1) + 1;
    localparam int MaxLow = 4096;

    logic              CLK = 1'b0;
    logic              RSTb = 1'b0;
    logic signed [15:0] x_in = '0;
    logic              in_tick = 1'b0;
    logic [5:0]        gain = '0;
    logic              clr_status = 1'b0;
    logic              in_req;
    logic signed [15:0] x_out;
    logic              underrun;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cic_interp #(
        .WIDTH(W), .INTERP(R), .BITS(16), .GAIN_BITS(6), .SHIFT_BASE(SB)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .x_in(x_in), .in_tick(in_tick), .gain(gain),
        .clr_status(clr_status), .in_req(in_req), .x_out(x_out),
        .underrun(underrun), .overrun(overrun)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint h [Taps];
    longint samp [MaxLow];
    int     n_edge;
    bit     m_pend;
    longint m_hold;
    bit     e_req, e_under, e_over;
    longint e_xout;
    bit     chk_en = 1'b0;
    bit     cons;
    int     jj;

    initial begin
        longint tmp [Taps];
        int len;
        for (int i = 0; i < Taps; i++) h[i] = 0;
        h[0] = 1;
        len = 1;
        repeat (5) begin
            for (int i = 0; i < len + R - 1; i++) begin
                tmp[i] = 0;
                for (int d = 0; d < R; d++)
                    if (i - d >= 0 && i - d < len) tmp[i] += h[i - d];
            end
            len = len + R - 1;
            for (int i = 0; i < len; i++) h[i] = tmp[i];
        end
    end

    function automatic longint conv(input int n);
        longint acc = 0;
        int m = n - 11;
        if (m < 0) return 0;
        for (int j = m / R; j >= 1; j--) begin
            int k = m - j * R;
            if (k >= Taps) break;
            if (j < MaxLow) acc += samp[j] * h[k];
        end
        return acc;
    endfunction

    function automatic longint model_out(input int n, input int g);
        longint v = conv(n);
        int sh = (g >= SB) ? 0 : SB - g;
        v = v >>> sh;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    always @(posedge CLK) begin
        if (!RSTb) begin
            n_edge = 0;
            for (int i = 0; i < MaxLow; i++) samp[i] = 0;
            m_pend = 0; m_hold = 0;
            e_req = 0; e_under = 0; e_over = 0; e_xout = 0;
        end else begin
            n_edge++;
            cons  = (n_edge % R) == 0;
            e_req = cons;
            if (clr_status) begin
                e_under = 0;
                e_over  = 0;
            end
            if (cons) begin
                jj = n_edge / R;
                if (jj < MaxLow) samp[jj] = m_pend ? m_hold : 0;
                if (!m_pend) e_under = 1;
            end
            if (in_tick && m_pend && !cons) e_over = 1;
            if (in_tick) begin
                m_pend = 1;
                m_hold = longint'(x_in);
            end else if (cons) begin
                m_pend = 0;
            end
            e_xout = model_out(n_edge, int'(gain));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("x_out", longint'(x_out), e_xout);
            check("in_req", longint'(in_req), longint'(e_req));
            check("underrun", longint'(underrun), longint'(e_under));
            check("overrun", longint'(overrun), longint'(e_over));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge CLK);
        RSTb = 1'b0; in_tick = 1'b0; clr_status = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
    endtask

    task automatic preload(input logic signed [15:0] v);
        in_tick = 1'b1; x_in = v;
        @(negedge CLK);
        in_tick = 1'b0;
    endtask

    task automatic feed(input int cycles, input logic signed [15:0] v);
        repeat (cycles) begin
            in_tick = in_req; x_in = v;
            @(negedge CLK);
        end
        in_tick = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!in_req && k < 4 * R) begin
            @(negedge CLK);
            k++;
        end
        check("req_wait", longint'(in_req), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int nz, first, k, glitch;
        longint sum, firstv;

        @(negedge CLK);
        chk_en = 1'b1;
        check("rst_xout", longint'(x_out), 0);
        check("rst_req", longint'(in_req), 0);

        // DC hold at unity gain
        do_reset();
        gain = 6'd0;
        preload(16'sd1000);
        feed(200, 16'sd1000);
        check("dc_value", longint'(x_out), 1000);
        check("dc_underrun", longint'(underrun), 0);
        check("dc_overrun", longint'(overrun), 0);

        // Impulse at shift 0
        do_reset();
        gain = 6'd12;
        in_tick = 1'b1; x_in = 16'sd1;
        nz = 0; sum = 0; first = -1; firstv = 0;
        for (int e = 1; e <= 80; e++) begin
            @(negedge CLK);
            if (x_out != 0) begin
                nz++;
                sum += longint'(x_out);
                if (first < 0) begin
                    first  = e;
                    firstv = longint'(x_out);
                end
            end
            in_tick = in_req; x_in = 16'sd0;
        end
        in_tick = 1'b0;
        check("imp_count", nz, 36);
        check("imp_sum", sum, 32768);
        check("imp_first_edge", first, R + 11);
        check("imp_first_value", firstv, 1);

        // Positive saturation
        do_reset();
        gain = 6'd12;
        preload(16'sd32767);
        glitch = 0;
        repeat (100) begin
            in_tick = in_req; x_in = 16'sd32767;
            @(negedge CLK);
            if (x_out < 0) glitch++;
        end
        in_tick = 1'b0;
        check("sat_pos", longint'(x_out), 32767);
        check("sat_pos_nowrap", glitch, 0);

        // Negative saturation
        do_reset();
        preload(-16'sd32768);
        glitch = 0;
        repeat (100) begin
            in_tick = in_req; x_in = -16'sd32768;
            @(negedge CLK);
            if (x_out > 0) glitch++;
        end
        in_tick = 1'b0;
        check("sat_neg", longint'(x_out), -32768);
        check("sat_neg_nowrap", glitch, 0);

        // Underrun: skip one request, then clear
        do_reset();
        gain = 6'd0;
        preload(16'sd1000);
        feed(60, 16'sd1000);
        wait_req();
        in_tick = 1'b0;
        @(negedge CLK);
        wait_req();
        check("underrun_set", longint'(underrun), 1);
        clr_status = 1'b1; in_tick = 1'b1; x_in = 16'sd1000;
        @(negedge CLK);
        clr_status = 1'b0; in_tick = 1'b0;
        check("underrun_clr", longint'(underrun), 0);

        // Overrun: two ticks between requests, the later one wins
        feed(40, 16'sd1000);
        wait_req();
        in_tick = 1'b1; x_in = 16'sd100;
        @(negedge CLK);
        x_in = 16'sd200;
        @(negedge CLK);
        in_tick = 1'b0;
        check("overrun_set", longint'(overrun), 1);
        wait_req();
        check("overrun_no_underrun", longint'(underrun), 0);
        clr_status = 1'b1; in_tick = 1'b1; x_in = 16'sd1000;
        @(negedge CLK);
        clr_status = 1'b0; in_tick = 1'b0;
        check("overrun_clr", longint'(overrun), 0);

        // Tick coincident with the consume edge
        repeat (R - 2) @(negedge CLK);
        in_tick = 1'b1; x_in = 16'sd500;
        @(negedge CLK);
        in_tick = 1'b0;
        check("coinc_on_consume", longint'(in_req), 1);
        check("coinc_no_overrun", longint'(overrun), 0);
        @(negedge CLK);
        wait_req();
        check("coinc_no_underrun", longint'(underrun), 0);
        feed(30, 16'sd500);
        check("pre_reset_nonzero", longint'(x_out != 0), 1);

        // Mid-run reset
        RSTb = 1'b0; in_tick = 1'b1; x_in = 16'sd500;
        @(negedge CLK);
        in_tick = 1'b0;
        check("mid_rst_xout", longint'(x_out), 0);
        check("mid_rst_req", longint'(in_req), 0);
        check("mid_rst_underrun", longint'(underrun), 0);
        check("mid_rst_overrun", longint'(overrun), 0);
        RSTb = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!in_req && k < 3 * R);
        check("req_after_release", k, R);
        repeat (4) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
# cic_interp

Five-stage CIC interpolator: the transmit-side counterpart to the receive decimator. It accepts signed low-rate samples on a request/tick handshake and zero-stuffs them by INTERP. It then produces one signed, gain-scaled, saturated output sample on every CLK cycle for the high-rate modulator/DAC path. The comb section runs at the low rate as a one-stage-per-clock pipeline; the integrator section runs at the clock rate.

## Interface
- WIDTH, 74: internal accumulator width; must be ≥ BITS + 4·ceil(log2 INTERP) + 5.
- INTERP, 5000: interpolation factor R (M = 1); legal range 8..65535.
- BITS, 16: input and output sample width.
- GAIN_BITS, 6: width of gain.
- SHIFT_BASE, 52: right shift applied at gain = 0.
- CLK  in  1  system clock; all state changes on the rising edge.
- RSTb  in  1  synchronous active-low reset.
- x_in  in  BITS  signed low-rate sample; valid when in_tick = 1.
- in_tick  in  1  one-cycle strobe; x_in is captured into the holding register.
- gain  in  GAIN_BITS  unsigned gain; effective shift = SHIFT_BASE − min(gain, SHIFT_BASE).
- clr_status  in  1  clears underrun and overrun.
- in_req  out  1  one-cycle pulse; the held sample was consumed and the next one is wanted.
- x_out  out  BITS  signed high-rate output, updated every cycle.
- underrun  out  1  sticky: a consume found no new sample.
- overrun  out  1  sticky: a held sample was overwritten before being consumed.

## Operation
- Phase counter (16 bit) counts 0..INTERP−1 and wraps to 0. A consume edge E is every edge at which phase == INTERP−1.
- Holding register and pending flag:
  - in_tick loads x_in and sets pending.
  - If pending is already set and no consume occurs on that edge, set overrun; the newer value wins.
- At consume edge E:
  - If pending: the comb input register takes the sign-extended held sample.
  - Otherwise: it takes 0 and underrun is set.
  - Pending clears.
  - in_req = 1 for the cycle following E.
- in_tick on edge E: the old held value is consumed, the new x_in becomes held, pending stays set, and no overrun is flagged.
- Comb pipeline: comb k (k = 1..5) computes in − in_del and updates its delay register once per low-rate sample, at edge E+k. Requires INTERP ≥ 6.
- Zero-stuff: integ1's input is comb5's output only on edge E+6; on every other edge it is 0.
- Integrators: integ1..integ5 accumulate every edge, wrapping two's complement in WIDTH bits; wraparound is intentional.
- Output:
  - x_out = saturate(integ5 >>> shift) to [−2^(BITS−1), 2^(BITS−1)−1], with an arithmetic shift.
  - gain is sampled every cycle; a gain change takes effect on the next output.
- DC gain is INTERP^4. SHIFT_BASE and gain set unity gain: with INTERP = 8 and SHIFT_BASE = 12, gain 0 gives exactly unity.
- clr_status clears both flags. Setting a flag has priority over clearing it on the same edge.

## Timing
- Reset (RSTb = 0 on an edge): counter, holding register, pending, all comb/integrator registers, in_req, underrun, overrun and x_out go to 0 on that edge. Reset mid-operation discards all in-flight data, with no partial output.
- First consume edge after reset release is the INTERP-th edge after release.
- Latency: an input consumed at E first affects integ5 at E+10 and x_out at E+11.
- in_req is high in exactly one cycle of every INTERP cycles.
- in_tick may arrive at any cycle, including during in_req.

## Test plan
- Reset, DC hold: INTERP = 8, SHIFT_BASE = 12, gain = 0; feed x_in = 1000 on every in_req.
  - x_out settles to exactly 1000 and stays constant.
  - underrun and overrun stay 0.
- Impulse: one sample of 1, then 0s; gain = 12 (shift 0).
  - 36 consecutive nonzero x_out values, summing to 32768.
  - The first nonzero value appears at E+11.
- Saturation: DC 32767 with shift 0 → x_out clamps at 32767; DC −32768 → x_out clamps at −32768; no wrap glitches.
- Underrun: withhold in_tick for one request.
  - underrun = 1 after the consume edge, and the zero is stuffed into the combs.
  - clr_status clears the flag the next cycle.
- Overrun and simultaneous events:
  - Two in_ticks (100, then 200) between requests → overrun = 1 and 200 is consumed.
  - in_tick coincident with the consume edge → no overrun.
- Mid-run reset: pulse RSTb low while the integrators are nonzero.
  - All outputs read 0 the cycle after.
  - in_req returns exactly INTERP edges after release.
